// File: rtl/vga_pkg.sv
// Shared VGA timing constants, counter width and colour packing for the 640x480@60 raster.
package vga_pkg;

    localparam int unsigned DefHActive = 640;
    localparam int unsigned DefHFp     = 16;
    localparam int unsigned DefHSync   = 96;
    localparam int unsigned DefHBp     = 48;
    localparam int unsigned DefVActive = 480;
    localparam int unsigned DefVFp     = 10;
    localparam int unsigned DefVSync   = 2;
    localparam int unsigned DefVBp     = 33;

    localparam int unsigned DefHTotal     = DefHActive + DefHFp + DefHSync + DefHBp;
    localparam int unsigned DefVTotal     = DefVActive + DefVFp + DefVSync + DefVBp;
    localparam int unsigned DefHSyncStart = DefHActive + DefHFp;
    localparam int unsigned DefHSyncEnd   = DefHSyncStart + DefHSync - 1;
    localparam int unsigned DefVSyncStart = DefVActive + DefVFp;
    localparam int unsigned DefVSyncEnd   = DefVSyncStart + DefVSync - 1;

    localparam int unsigned CntW   = 10;
    localparam int unsigned CntMax = 1 << CntW;

    typedef logic [CntW-1:0] cnt_t;

    // Board colour layout {R[2:0], G[2:0], B[1:0]}.
    typedef struct packed {
        logic [2:0] red;
        logic [2:0] green;
        logic [1:0] blue;
    } rgb_t;

    function automatic logic in_range(input cnt_t v, input int unsigned lo,
                                      input int unsigned hi);
        return (v >= cnt_t'(lo)) && (v <= cnt_t'(hi));
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Renderer/pin-side signal bundle of the VGA sync generator.
interface vga_sync_gen_if;
    import vga_pkg::*;

    logic       pix_tick;
    logic [7:0] rgb_in;
    cnt_t       pixel_x;
    cnt_t       pixel_y;
    logic       video_on;
    logic       frame_tick;
    logic       Hsync;
    logic       Vsync;
    logic [2:0] vgaRed;
    logic [2:0] vgaGreen;
    logic [2:1] vgaBlue;

    modport master (
        output pix_tick, rgb_in,
        input  pixel_x, pixel_y, video_on, frame_tick, Hsync, Vsync,
        input  vgaRed, vgaGreen, vgaBlue
    );

    modport slave (
        input  pix_tick, rgb_in,
        output pixel_x, pixel_y, video_on, frame_tick, Hsync, Vsync,
        output vgaRed, vgaGreen, vgaBlue
    );

endinterface

// File: rtl/vga_axis_counter.sv
// Enabled modulo-Total counter; wrap_o flags the last count so the next enable returns to 0.
module vga_axis_counter #(
    parameter int unsigned Total = 800,
    parameter int unsigned Width = 10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    output logic [Width-1:0] cnt_o,
    output logic             wrap_o
);

    localparam logic [Width-1:0] Last = Width'(Total - 1);

    logic [Width-1:0] cnt_q, cnt_d;

    assign wrap_o = (cnt_q == Last);
    assign cnt_o  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing: pixel counters, registered sync/colour pins and a per-frame strobe.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DefHActive,
    parameter int unsigned H_FP     = DefHFp,
    parameter int unsigned H_SYNC   = DefHSync,
    parameter int unsigned H_BP     = DefHBp,
    parameter int unsigned V_ACTIVE = DefVActive,
    parameter int unsigned V_FP     = DefVFp,
    parameter int unsigned V_SYNC   = DefVSync,
    parameter int unsigned V_BP     = DefVBp
) (
    input logic           clk,
    input logic           rst_n,
    vga_sync_gen_if.slave bus
);

    localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HSyncStart   = H_ACTIVE + H_FP;
    localparam int unsigned HSyncEnd     = HSyncStart + H_SYNC - 1;
    localparam int unsigned VSyncStart   = V_ACTIVE + V_FP;
    localparam int unsigned VSyncEnd     = VSyncStart + V_SYNC - 1;
    localparam cnt_t        VLastActive  = cnt_t'(V_ACTIVE - 1);

    if ((H_TOTAL > CntMax) || (V_TOTAL > CntMax)) begin : g_total_check
        $error("vga_sync_gen: H_TOTAL/V_TOTAL exceed the 10-bit counter range");
    end

    cnt_t h_cnt, v_cnt;
    logic h_wrap, v_wrap, video_on;

    vga_axis_counter #(
        .Total (H_TOTAL),
        .Width (CntW)
    ) u_h_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (bus.pix_tick),
        .cnt_o  (h_cnt),
        .wrap_o (h_wrap)
    );

    vga_axis_counter #(
        .Total (V_TOTAL),
        .Width (CntW)
    ) u_v_cnt (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .en_i   (bus.pix_tick & h_wrap),
        .cnt_o  (v_cnt),
        .wrap_o (v_wrap)
    );

    assign video_on = (h_cnt < cnt_t'(H_ACTIVE)) && (v_cnt < cnt_t'(V_ACTIVE));

    logic hs_q, hs_d, vs_q, vs_d, frame_q, frame_d;
    rgb_t rgb_q, rgb_d;

    // Pins describe the pixel the counters held when the tick arrived (one pixel lag).
    always_comb begin
        hs_d    = hs_q;
        vs_d    = vs_q;
        rgb_d   = rgb_q;
        frame_d = 1'b0;
        if (bus.pix_tick) begin
            hs_d    = !in_range(h_cnt, HSyncStart, HSyncEnd);
            vs_d    = !in_range(v_cnt, VSyncStart, VSyncEnd);
            rgb_d   = video_on ? rgb_t'(bus.rgb_in) : '0;
            frame_d = h_wrap && (v_cnt == VLastActive);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            rgb_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            rgb_q   <= rgb_d;
            frame_q <= frame_d;
        end
    end

    assign bus.pixel_x    = h_cnt;
    assign bus.pixel_y    = v_cnt;
    assign bus.video_on   = video_on;
    assign bus.frame_tick = frame_q;
    assign bus.Hsync      = hs_q;
    assign bus.Vsync      = vs_q;
    assign bus.vgaRed     = rgb_q.red;
    assign bus.vgaGreen   = rgb_q.green;
    assign bus.vgaBlue    = rgb_q.blue;

    // End of frame: both axes must land on (0,0) together.
    frame_wrap_a: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.pix_tick && h_wrap && v_wrap) |=> ((h_cnt == '0) && (v_cnt == '0)));

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: full-size raster for line timing, a shrunken raster for vertical/frame/wrap.
module tb_vga_sync_gen;
    import vga_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       pix_tick;
    logic [7:0] rgb_in;

    vga_sync_gen_if bus ();
    vga_sync_gen_if bus_s ();

    assign bus.pix_tick   = pix_tick;
    assign bus.rgb_in     = rgb_in;
    assign bus_s.pix_tick = pix_tick;
    assign bus_s.rgb_in   = rgb_in;

    vga_sync_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Small raster: 16 pixels x 12 lines, hsync on h 10..12, vsync on v 8..9, frame = 192 ticks.
    vga_sync_gen #(
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (3),
        .V_ACTIVE (6),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (2)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_s.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          sel;
        int unsigned tick;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        von;
        logic [7:0]  rgb;
        logic        ft;
    } vec_t;

    vec_t vecs[$];

    int unsigned n_cmp, n_bad;
    int unsigned tick_n, period, idles_done;
    int unsigned hs_low, vb_bad, frame_hi, frame_cnt;
    int unsigned frame_at[16];

    function automatic vec_t mk(input bit sel, input int unsigned tick, input int unsigned x,
                                input int unsigned y, input logic hs, input logic vs,
                                input logic von, input logic [7:0] rgb, input logic ft);
        vec_t v;
        v.sel = sel; v.tick = tick; v.x = 10'(x); v.y = 10'(y);
        v.hs = hs; v.vs = vs; v.von = von; v.rgb = rgb; v.ft = ft;
        return v;
    endfunction

    function automatic logic [31:0] snap(input bit sel);
        if (sel) begin
            return {bus_s.pixel_x, bus_s.pixel_y, bus_s.Hsync, bus_s.Vsync, bus_s.video_on,
                    bus_s.vgaRed, bus_s.vgaGreen, bus_s.vgaBlue, bus_s.frame_tick};
        end
        return {bus.pixel_x, bus.pixel_y, bus.Hsync, bus.Vsync, bus.video_on,
                bus.vgaRed, bus.vgaGreen, bus.vgaBlue, bus.frame_tick};
    endfunction

    function automatic logic [31:0] pack(input vec_t v);
        return {v.x, v.y, v.hs, v.vs, v.von, v.rgb, v.ft};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic observe(input bit tk);
        if (bus_s.frame_tick) begin
            frame_hi++;
            if (tk && frame_cnt < 16) frame_at[frame_cnt] = tick_n;
            if (tk) frame_cnt++;
        end
        if (tk && tick_n <= 800 && !bus.Hsync) hs_low++;
        if (tk && ((tick_n >= 97 && tick_n <= 192) || (tick_n >= 289 && tick_n <= 384))
            && ({bus_s.vgaRed, bus_s.vgaGreen, bus_s.vgaBlue} != 8'h00)) vb_bad++;
    endtask

    task automatic clk_step(input bit tk);
        pix_tick = tk;
        @(posedge clk);
        #1;
        pix_tick = 1'b0;
        if (tk) tick_n++;
        observe(tk);
    endtask

    task automatic run_to(input int unsigned target);
        while (tick_n < target) begin
            for (int unsigned c = idles_done; c < period - 1; c++) clk_step(1'b0);
            idles_done = 0;
            clk_step(1'b1);
        end
    endtask

    task automatic reset_checks(input string tag);
        vec_t r;
        r = mk(1'b0, 0, 0, 0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
        check({tag, "_full"}, snap(1'b0), pack(r));
        check({tag, "_small"}, snap(1'b1), pack(r));
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0; pix_tick = 1'b0; rgb_in = 8'hFF;

        // Full raster (sel 0) and small raster (sel 1), ascending tick order.
        vecs.push_back(mk(0,    1,   1, 0, 1, 1, 1, 8'hFF, 0));
        vecs.push_back(mk(1,    8,   8, 0, 1, 1, 0, 8'hFF, 0));
        vecs.push_back(mk(1,    9,   9, 0, 1, 1, 0, 8'h00, 0));
        vecs.push_back(mk(1,   11,  11, 0, 0, 1, 0, 8'h00, 0));
        vecs.push_back(mk(1,   13,  13, 0, 0, 1, 0, 8'h00, 0));
        vecs.push_back(mk(1,   14,  14, 0, 1, 1, 0, 8'h00, 0));
        vecs.push_back(mk(1,   95,  15, 5, 1, 1, 0, 8'h00, 0));
        vecs.push_back(mk(1,   96,   0, 6, 1, 1, 0, 8'h00, 1));
        vecs.push_back(mk(1,   97,   1, 6, 1, 1, 0, 8'h00, 0));
        vecs.push_back(mk(1,  128,   0, 8, 1, 1, 0, 8'h00, 0));
        vecs.push_back(mk(1,  129,   1, 8, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1,  160,   0, 10, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(1,  161,   1, 10, 1, 1, 0, 8'h00, 0));
        vecs.push_back(mk(1,  191,  15, 11, 1, 1, 0, 8'h00, 0));
        vecs.push_back(mk(1,  192,   0, 0, 1, 1, 1, 8'h00, 0));
        vecs.push_back(mk(1,  193,   1, 0, 1, 1, 1, 8'hFF, 0));
        vecs.push_back(mk(1,  288,   0, 6, 1, 1, 0, 8'h00, 1));
        vecs.push_back(mk(1,  321,   1, 8, 1, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0,  640, 640, 0, 1, 1, 0, 8'hFF, 0));
        vecs.push_back(mk(0,  641, 641, 0, 1, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0,  656, 656, 0, 1, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0,  657, 657, 0, 0, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0,  752, 752, 0, 0, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0,  753, 753, 0, 1, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0,  799, 799, 0, 1, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0,  800,   0, 1, 1, 1, 1, 8'h00, 0));
        vecs.push_back(mk(0,  801,   1, 1, 1, 1, 1, 8'hFF, 0));
        vecs.push_back(mk(0, 1456, 656, 1, 1, 1, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1457, 657, 1, 0, 1, 0, 8'h00, 0));

        repeat (3) @(posedge clk);
        #1;
        reset_checks("reset_initial");

        for (int m = 0; m < 2; m++) begin
            period = (m == 0) ? 1 : 4;
            tick_n = 0; idles_done = 0;
            hs_low = 0; vb_bad = 0; frame_hi = 0; frame_cnt = 0;
            for (int k = 0; k < 16; k++) frame_at[k] = 0;
            #2 rst_n = 1'b1;

            foreach (vecs[i]) begin
                vec_t v;
                v = vecs[i];
                run_to(v.tick);
                check($sformatf("m%0d_%s_tick%0d", m, v.sel ? "small" : "full", v.tick),
                      snap(v.sel), pack(v));
                if (period > 1) begin
                    for (int unsigned c = 0; c < period - 1; c++) clk_step(1'b0);
                    idles_done = period - 1;
                    v.ft = 1'b0;
                    check($sformatf("m%0d_%s_hold%0d", m, v.sel ? "small" : "full", v.tick),
                          snap(v.sel), pack(v));
                end
            end

            check($sformatf("m%0d_hsync_low_ticks", m), 32'(hs_low), 32'd96);
            check($sformatf("m%0d_vblank_colour", m), 32'(vb_bad), 32'd0);
            check($sformatf("m%0d_frame_pulses", m), 32'(frame_cnt), 32'd8);
            check($sformatf("m%0d_frame_high_clks", m), 32'(frame_hi), 32'd8);
            check($sformatf("m%0d_frame_first", m), 32'(frame_at[0]), 32'd96);
            check($sformatf("m%0d_frame_second", m), 32'(frame_at[1]), 32'd288);
            check($sformatf("m%0d_frame_last", m), 32'(frame_at[7]), 32'd1440);

            // Asynchronous reset between clock edges while the full raster is inside hsync.
            #2 rst_n = 1'b0;
            #1;
            reset_checks($sformatf("m%0d_reset_midline", m));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the 640x480 @ 60 Hz VGA output. It sits directly downstream of the pixel-rate divider and consumes its one-cycle `pix_tick` enable. It produces the pixel coordinates the sprite/background renderer uses to compute a colour, and registers that colour together with the sync pulses onto the board VGA pins. It also emits a once-per-frame strobe that the game logic uses to update state during vertical blanking.

## Interface
- `H_ACTIVE` 640, `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal timing, in pixels.
- `V_ACTIVE` 480, `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical timing, in lines.
- `clk` input 1: system clock. Single clock domain.
- `rst_n` input 1: reset, asynchronous, active-low.
- `pix_tick` input 1: pixel enable, one `clk` wide, from the divider.
- `rgb_in` input 8: renderer colour {R[2:0], G[2:0], B[1:0]} for the current `pixel_x`/`pixel_y`.
- `pixel_x` output 10: horizontal counter `h_cnt`.
- `pixel_y` output 10: vertical counter `v_cnt`.
- `video_on` output 1: current counter position is inside the active area.
- `frame_tick` output 1: one-`clk` strobe at the start of vertical blanking.
- `Hsync`, `Vsync` output 1 each: active-low sync pulses, registered.
- `vgaRed` output 3, `vgaGreen` output 3, `vgaBlue` output 2 (bits [2:1]): registered, blanked colour.

## Operation
- H_TOTAL = 800 and V_TOTAL = 525, both derived from the parameters. Both totals must be ≤ 1024; violating this is an elaboration error.
- State changes only on a `clk` edge with `pix_tick`=1. With `pix_tick`=0, every register holds, except `frame_tick`, which clears.
- `h_cnt` counts 0..H_TOTAL-1, then wraps to 0.
- `v_cnt` increments only on the tick where `h_cnt` wraps, and itself wraps from V_TOTAL-1 to 0.
- `video_on` is combinational: (`h_cnt` < H_ACTIVE) && (`v_cnt` < V_ACTIVE).
- `pixel_x`/`pixel_y` drive the raw counters, including during blanking. The renderer ignores them when `video_on`=0.
- On each `pix_tick`, the output registers load from the *current* counters:
  - `Hsync` ← 0 iff `h_cnt` ∈ [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. [656, 751].
  - `Vsync` ← 0 iff `v_cnt` ∈ [490, 491].
  - Colour ← `rgb_in` if `video_on`, else 0.
- `frame_tick` is high for exactly the one `clk` cycle that follows the `pix_tick` on which `h_cnt`=H_TOTAL-1 and `v_cnt`=V_ACTIVE-1.
- Reset values:
  - `h_cnt` = `v_cnt` = 0, so `video_on` = 1.
  - `Hsync` = `Vsync` = 1.
  - Colour = 0, `frame_tick` = 0.
- Reset mid-frame: all registers return to their reset values immediately, without waiting for a `clk` edge. The next `pix_tick` after release is treated as pixel (0,0).

## Timing
- The renderer has exactly one pixel period to respond. `rgb_in` is sampled on the `pix_tick` edge that also advances the counters.
- Pins lag the counters by one pixel: sync and colour registered on tick k describe pixel k-1, counted from reset.
- Counting ticks from reset (tick 1 sees `h_cnt`=0):
  - `Hsync` falls after tick 657 and rises after tick 753.
  - `Vsync` falls after tick 392001 and rises after tick 393601.
  - `frame_tick` pulses after tick 384000. Frame period is 420000 ticks.
- Continuous `pix_tick`=1 is legal; the block then advances every `clk`, which shortens simulation.
- When `h_cnt` and `v_cnt` wrap on the same tick, both return to 0 on that tick.

## Structure
- Package `vga_pkg` holds:
  - the eight default timing constants;
  - the derived H_TOTAL, V_TOTAL, the sync start/end positions, and the counter width (10);
  - the 8-bit colour packing layout.
- Sub-module `vga_axis_counter`: a parameterised wrap counter with `en` input and `wrap` output.
  - Horizontal instance: `en`=`pix_tick`.
  - Vertical instance: `en`=`pix_tick` & h-`wrap`.
- The top of the block holds the sync/colour output registers and the `frame_tick` register.

## Test plan
- Reset check: assert `rst_n`=0 mid-line with no clock edge. All outputs go to their reset values asynchronously. `pixel_x`=0, `pixel_y`=0, `Hsync`=`Vsync`=1, colour=0.
- Horizontal timing: `pix_tick`=1 continuously. `Hsync` is low for exactly 96 ticks, first falling after tick 657. Line period is 800 ticks.
- Blanking: `rgb_in`=8'hFF. Colour reads 0xFF after ticks 1..640 and 0 after ticks 641..800 of each active line. Colour stays 0 for the whole of lines 480..524.
- Vertical and frame: `Vsync` is low for 1600 ticks starting after tick 392001. `frame_tick` is one `clk` wide, after tick 384000, then every 420000 ticks.
- Enable gaps: `pix_tick` every 4th `clk`. Counters and outputs hold between ticks. Every edge lands at the same tick counts as above. `frame_tick` stays one `clk` wide.
- Wrap: run through tick 420000. `pixel_x` and `pixel_y` return to (0,0) together. The next frame is identical to the first.
